// File: rtl/mult8_pkg.sv
// Shared types and constants for the nibble-serial 8x8 multiplier controller.
// Step order and shift amounts live here so the datapath and any future users agree.
package mult8_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int STEPS = 4;
    localparam int NIB   = 4;

    localparam logic [1:0] LAST_STEP = 2'(STEPS - 1);

    // Shift applied to each step's 8-bit partial product before accumulation.
    localparam logic [3:0] SHIFT [STEPS] = '{4'd0, 4'd4, 4'd4, 4'd8};

endpackage

// File: rtl/multiplier.sv
// Unsigned 4x4 -> 8 combinational array multiplier.
// Purely combinational: no latency, no flow control.
module multiplier (
    input  logic [3:0] x,
    input  logic [3:0] y,
    output logic [7:0] z
);

    always_comb begin
        z = '0;
        for (int i = 0; i < 4; i++) begin
            if (y[i]) begin
                z = z + ({4'b0, x} << i);
            end
        end
    end

endmodule

// File: rtl/mult8_seq_ctrl.sv
// Unsigned 8x8 -> 16 product over four cycles through one shared 4x4 multiplier.
// Start accepted only in IDLE; done pulses 5 cycles after acceptance; start while busy is dropped.
module mult8_seq_ctrl
    import mult8_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    output logic        busy,
    output logic        done,
    output logic [15:0] p
);

    state_t      state_q, state_d;
    logic [1:0]  step_q,  step_d;
    logic [15:0] acc_q,   acc_d;
    logic [7:0]  a_q,     a_d;
    logic [7:0]  b_q,     b_d;
    logic [15:0] p_q,     p_d;

    logic [3:0]  mul_x;
    logic [3:0]  mul_y;
    logic [7:0]  prod;
    logic [15:0] term;
    logic [15:0] acc_sum;

    // step[0] picks the high nibble of a, step[1] the high nibble of b.
    assign mul_x = step_q[0] ? a_q[2*NIB-1:NIB] : a_q[NIB-1:0];
    assign mul_y = step_q[1] ? b_q[2*NIB-1:NIB] : b_q[NIB-1:0];

    multiplier u_mul (
        .x (mul_x),
        .y (mul_y),
        .z (prod)
    );

    assign term    = {8'b0, prod} << SHIFT[step_q];
    assign acc_sum = acc_q + term;

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        acc_d   = acc_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        case (state_q)
            IDLE: begin
                step_d = '0;
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d  = acc_sum;
                step_d = step_q + 2'd1;
                if (step_q == LAST_STEP) begin
                    p_d     = acc_sum;
                    state_d = DONE;
                end
            end
            DONE: begin
                step_d  = '0;
                state_d = IDLE;
            end
            default: begin
                step_d  = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            step_q  <= '0;
            acc_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == DONE);
    assign p    = p_q;

endmodule

// File: tb/tb_mult8_seq_ctrl.sv
// Directed and swept checks of mult8_seq_ctrl: latency, handshake, hold, reset abort.
module tb_mult8_seq_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] p;

    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    mult8_seq_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .p     (p)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one accepted start and follows it to completion (bounded).
    // lat = clock edges after the accepting edge before done is seen.
    task automatic run_op(input logic [7:0] oa, input logic [7:0] ob,
                          output logic [15:0] p_done, output int n_done,
                          output int n_busy, output int lat, output bit p_early);
        logic [15:0] p_init;
        p_init  = p;
        start   = 1'b1;
        a       = oa;
        b       = ob;
        tick();
        start   = 1'b0;
        n_done  = 0;
        n_busy  = 0;
        lat     = -1;
        p_done  = '0;
        p_early = 1'b0;
        for (int k = 0; k < 16; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if (busy) n_busy++;
            if (done) begin
                n_done++;
                if (lat < 0) lat = k;
                p_done = p;
            end else if (n_done == 0 && p !== p_init) begin
                p_early = 1'b1;
            end
            if (!busy && !done) break;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        #12;
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy got %b want 0", busy); end
        tests_run++;
        if (done !== 1'b0) begin tests_failed++; $display("FAIL reset_done got %b want 0", done); end
        tests_run++;
        if (p !== 16'h0000) begin tests_failed++; $display("FAIL reset_p got %h want 0000", p); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        logic [15:0] pd; int nd, nb, lat; bit early;
        run_op(8'h12, 8'h34, pd, nd, nb, lat, early);
        tests_run++;
        if (pd !== 16'h03A8) begin tests_failed++; $display("FAIL basic_p got %h want 03a8", pd); end
        tests_run++;
        if (nb != 5) begin tests_failed++; $display("FAIL basic_busy_cycles got %0d want 5", nb); end
        tests_run++;
        if (lat != 4) begin tests_failed++; $display("FAIL basic_latency got %0d want 4", lat); end
        tests_run++;
        if (nd != 1) begin tests_failed++; $display("FAIL basic_done_count got %0d want 1", nd); end
        tests_run++;
        if (early) begin tests_failed++; $display("FAIL basic_p_early got 1 want 0"); end
    endtask

    task automatic test_max();
        logic [15:0] pd; int nd, nb, lat; bit early;
        run_op(8'hFF, 8'hFF, pd, nd, nb, lat, early);
        tests_run++;
        if (pd !== 16'hFE01) begin tests_failed++; $display("FAIL max_p got %h want fe01", pd); end
        tests_run++;
        if (nd != 1) begin tests_failed++; $display("FAIL max_done_count got %0d want 1", nd); end
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++; $display("FAIL max_after_idle got busy=%b done=%b want 0 0", busy, done);
        end
        tests_run++;
        if (p !== 16'hFE01) begin tests_failed++; $display("FAIL max_p_hold got %h want fe01", p); end
    endtask

    task automatic test_p_hold();
        logic [15:0] pd; int nd, nb, lat; bit early;
        run_op(8'h00, 8'hA7, pd, nd, nb, lat, early);
        tests_run++;
        if (pd !== 16'h0000) begin tests_failed++; $display("FAIL zero_p got %h want 0000", pd); end
        tests_run++;
        if (early) begin tests_failed++; $display("FAIL zero_p_early got 1 want 0"); end
        run_op(8'h0F, 8'hF0, pd, nd, nb, lat, early);
        tests_run++;
        if (early) begin tests_failed++; $display("FAIL hold_p_early got 1 want 0"); end
        tests_run++;
        if (pd !== 16'h0E10) begin tests_failed++; $display("FAIL hold_p got %h want 0e10", pd); end
    endtask

    task automatic test_start_held();
        bit seen;
        start = 1'b1;
        a     = 8'h03;
        b     = 8'h05;
        tick();
        for (int k = 0; k < 5; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if (k == 4) begin
                tests_run++;
                if (done !== 1'b1) begin tests_failed++; $display("FAIL held_done got %b want 1", done); end
                tests_run++;
                if (p !== 16'h000F) begin tests_failed++; $display("FAIL held_p got %h want 000f", p); end
            end else begin
                tests_run++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    tests_failed++; $display("FAIL held_busy k=%0d got busy=%b done=%b want 1 0", k, busy, done);
                end
            end
            tick();
        end
        tests_run++;
        if (busy !== 1'b0) begin tests_failed++; $display("FAIL held_idle_gap got busy=%b want 0", busy); end
        a = 8'h02;
        b = 8'h07;
        tick();
        tests_run++;
        if (busy !== 1'b1) begin tests_failed++; $display("FAIL held_reaccept got busy=%b want 1", busy); end
        start = 1'b0;
        seen  = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            a = 8'($urandom);
            b = 8'($urandom);
            if (done) seen = 1'b1;
            else tick();
        end
        tests_run++;
        if (!seen || p !== 16'h000E) begin
            tests_failed++; $display("FAIL held_second_p got %h done_seen=%b want 000e", p, seen);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        logic [15:0] pd; int nd, nb, lat; bit early;
        start = 1'b1;
        a     = 8'h80;
        b     = 8'h80;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (p !== 16'h0000) begin tests_failed++; $display("FAIL midrst_p got %h want 0000", p); end
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            tests_failed++; $display("FAIL midrst_flags got busy=%b done=%b want 0 0", busy, done);
        end
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        tests_run++;
        if (busy !== 1'b0 || p !== 16'h0000) begin
            tests_failed++; $display("FAIL midrst_release got busy=%b p=%h want 0 0000", busy, p);
        end
        run_op(8'h80, 8'h80, pd, nd, nb, lat, early);
        tests_run++;
        if (pd !== 16'h4000 || nd != 1) begin
            tests_failed++; $display("FAIL midrst_reop got p=%h dones=%0d want 4000 1", pd, nd);
        end
    endtask

    task automatic test_sweep();
        logic [7:0]  corners [5];
        logic [7:0]  oa, ob;
        logic [15:0] expv, pd;
        int nd, nb, lat; bit early;
        corners = '{8'h00, 8'h01, 8'h0F, 8'hF0, 8'hFF};
        for (int n = 0; n < 1025; n++) begin
            if (n < 25) begin
                oa = corners[n / 5];
                ob = corners[n % 5];
            end else begin
                oa = 8'($urandom);
                ob = 8'($urandom);
            end
            expv = {8'b0, oa} * {8'b0, ob};
            run_op(oa, ob, pd, nd, nb, lat, early);
            tests_run++;
            if (pd !== expv) begin
                tests_failed++; $display("FAIL sweep_p a=%h b=%h got %h want %h", oa, ob, pd, expv);
            end
            tests_run++;
            if (nd != 1) begin
                tests_failed++; $display("FAIL sweep_done a=%h b=%h got %0d want 1", oa, ob, nd);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_p_hold();
        test_start_held();
        test_reset_mid();
        test_sweep();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
